pattern_check: RTL and testbench

Serial pattern checker: the receive end of the fixed 32-bit repeating test pattern used in the HDB3 path. Sits after the HDB3 decoder in the loopback bench and on silicon test paths. Consumes one recovered bit per qualified clock and aligns to the pattern phase. Once locked, flags and counts every bit error, and declares loss of lock on a burst of consecutive errors.

---
 rtl/hdb3_pkg.sv | 13 +
 rtl/pattern_check_sat_counter.sv | 34 +++
 rtl/pattern_check.sv | 137 +++++++++++++
 tb/tb_pattern_check.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/hdb3_pkg.sv
// Shared definitions for the HDB3 test-pattern path: the pattern word
// common to generator and checker, and the checker state encoding.
package hdb3_pkg;

  localparam logic [31:0] PATTERN_DEF = 32'h8900_F080;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } chk_state_e;

endpackage

// File: rtl/pattern_check_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority
// over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_r;

  // count register: clear wins over increment, increment stops at all-ones
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r <= CNT_ZERO;
    end else if (i_clr) begin
      cnt_r <= CNT_ZERO;
    end else if (i_inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign o_cnt = cnt_r;

endmodule

// File: rtl/pattern_check.sv
// Receive-side checker for the repeating 32-bit HDB3 test pattern:
// aligns to the pattern phase, then flags and counts bit errors.
import hdb3_pkg::*;

module pattern_check #(
  parameter logic [31:0] PATTERN  = PATTERN_DEF,
  parameter int          LOCK_CNT = 32,
  parameter int          LOSS_CNT = 4,
  parameter int          CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_data,
  input  logic             i_valid,
  input  logic             i_clr,
  output logic             o_lock,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam logic [7:0] LOCK_C = LOCK_CNT[7:0];
  localparam logic [7:0] LOSS_C = LOSS_CNT[7:0];

  chk_state_e  state_r, state_s;
  logic [31:0] win_r, win_s, nxt_win_s;
  logic [5:0]  fill_r, fill_s;
  logic [4:0]  ph_r, ph_s;
  logic [7:0]  match_r, match_s;
  logic [7:0]  loss_r, loss_s;
  logic        lock_r, lock_s;
  logic        err_r, err_s;
  logic        bit_ok_s;

  // next-state, phase tracking and error detection
  always_comb begin
    state_s   = state_r;
    win_s     = win_r;
    fill_s    = fill_r;
    ph_s      = ph_r;
    match_s   = match_r;
    loss_s    = loss_r;
    lock_s    = lock_r;
    err_s     = 1'b0;
    nxt_win_s = {win_r[30:0], i_data};
    bit_ok_s  = (i_data == PATTERN[ph_r]);
    if (i_valid) begin
      win_s = nxt_win_s;
      if (fill_r != 6'd32) begin
        fill_s = fill_r + 6'd1;
      end else begin
        fill_s = fill_r;
      end
      ph_s = ph_r - 5'd1;
      case (state_r)
        SEARCH: begin
          // fill_r of 31 already counts this bit as the 32nd
          if ((fill_r >= 6'd31) && (nxt_win_s == PATTERN)) begin
            state_s = VERIFY;
            ph_s    = 5'd31;
            match_s = 8'd0;
          end else begin
            state_s = SEARCH;
          end
        end
        VERIFY: begin
          if (bit_ok_s) begin
            if ((match_r + 8'd1) == LOCK_C) begin
              state_s = LOCK;
              lock_s  = 1'b1;
              loss_s  = 8'd0;
              match_s = 8'd0;
            end else begin
              match_s = match_r + 8'd1;
            end
          end else begin
            state_s = SEARCH;
          end
        end
        LOCK: begin
          if (bit_ok_s) begin
            loss_s = 8'd0;
          end else begin
            err_s = 1'b1;
            if ((loss_r + 8'd1) == LOSS_C) begin
              state_s = SEARCH;
              lock_s  = 1'b0;
              loss_s  = 8'd0;
            end else begin
              loss_s = loss_r + 8'd1;
            end
          end
        end
        default: begin
          state_s = SEARCH;
          lock_s  = 1'b0;
        end
      endcase
    end else begin
      err_s = 1'b0;
    end
  end

  // state, window, phase and counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= SEARCH;
      win_r   <= 32'd0;
      fill_r  <= 6'd0;
      ph_r    <= 5'd31;
      match_r <= 8'd0;
      loss_r  <= 8'd0;
      lock_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      win_r   <= win_s;
      fill_r  <= fill_s;
      ph_r    <= ph_s;
      match_r <= match_s;
      loss_r  <= loss_s;
      lock_r  <= lock_s;
      err_r   <= err_s;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (err_s),
    .i_clr   (i_clr),
    .o_cnt   (o_err_cnt)
  );

  assign o_lock = lock_r;
  assign o_err  = err_r;

endmodule

// File: tb/tb_pattern_check.sv
// Directed self-checking bench for pattern_check: default instance plus a
// narrow-counter instance used for saturation and clear-vs-error checks.
`timescale 1ns/1ps
module tb_pattern_check;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data, valid, clr;
  logic        a_lock, a_err, b_lock, b_err;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;
  logic [31:0] pat = 32'h8900_F080;
  int          checks, errors, gi;

  always #5 clk = ~clk;

  pattern_check dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .i_clr(clr),
    .o_lock(a_lock), .o_err(a_err), .o_err_cnt(a_cnt)
  );

  pattern_check #(.CNT_W(4), .LOSS_CNT(255)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .i_clr(clr),
    .o_lock(b_lock), .o_err(b_err), .o_err_cnt(b_cnt)
  );

  function automatic logic gen(input int k);
    return pat[31 - (k % 32)];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic d, input logic v, input logic c);
    data = d; valid = v; clr = c;
    @(posedge clk); #1;
  endtask

  task automatic clean_bits(input int n);
    for (int i = 0; i < n; i++) begin
      step(gen(gi), 1'b1, 1'b0);
      gi++;
    end
  endtask

  task automatic err_bit(input logic c);
    step(~gen(gi), 1'b1, c);
    gi++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = 1'b0; clr = 1'b0; data = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; gi = 0;
    rst_n = 1'b0; data = 1'b0; valid = 1'b0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lock", a_lock, 0);
    chk("rst_err", a_err, 0);
    chk("rst_cnt", a_cnt, 0);
    rst_n = 1'b1;

    // idle with i_valid low: nothing moves
    for (int i = 0; i < 100; i++) begin
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      chk("idle_lock", a_lock, 0);
      chk("idle_err", a_err, 0);
      chk("idle_cnt", a_cnt, 0);
    end

    // clean stream: VERIFY at bit 32, lock at bit 64
    gi = 0;
    for (int i = 0; i < 64; i++) begin
      clean_bits(1);
      chk("acq_err", a_err, 0);
      if (gi == 31) chk("acq_search", dut_a.state_r, 0);
      if (gi == 32) chk("acq_verify", dut_a.state_r, 1);
      if (gi == 63) chk("acq_lock63", a_lock, 0);
    end
    chk("acq_lock64", a_lock, 1);
    chk("acq_cnt", a_cnt, 0);

    // isolated errors while locked
    clean_bits(5);
    err_bit(1'b0);
    chk("e1_err", a_err, 1);
    chk("e1_cnt", a_cnt, 1);
    chk("e1_lock", a_lock, 1);
    clean_bits(1);
    chk("e1_err_low", a_err, 0);
    chk("e1_cnt_hold", a_cnt, 1);
    clean_bits(10);
    err_bit(1'b0);
    chk("e2_err", a_err, 1);
    chk("e2_cnt", a_cnt, 2);
    clean_bits(1);
    chk("e2_err_low", a_err, 0);
    clean_bits(7);
    err_bit(1'b0);
    chk("e3_cnt", a_cnt, 3);
    chk("e3_lock", a_lock, 1);

    // burst of 4 ending on a word boundary, then recover
    while ((gi % 32) != 28) clean_bits(1);
    for (int k = 1; k <= 4; k++) begin
      err_bit(1'b0);
      chk("burst_err", a_err, 1);
      chk("burst_lock", a_lock, (k < 4) ? 1 : 0);
    end
    chk("burst_cnt", a_cnt, 7);
    for (int i = 0; i < 64; i++) begin
      clean_bits(1);
      chk("rec_err", a_err, 0);
      if (i == 31) chk("rec_verify", dut_a.state_r, 1);
      if (i == 62) chk("rec_lock63", a_lock, 0);
    end
    chk("rec_lock64", a_lock, 1);
    chk("rec_cnt", a_cnt, 7);

    // gapped stream: junk data on invalid cycles is ignored
    do_reset();
    chk("gap_rst_cnt", a_cnt, 0);
    gi = 0;
    for (int c = 1; c <= 128; c++) begin
      if ((c % 2) == 1) begin
        clean_bits(1);
      end else begin
        step(~gen(gi), 1'b0, 1'b0);
      end
      chk("gap_err", a_err, 0);
      if (c == 126) chk("gap_lock126", a_lock, 0);
      if (c == 127) chk("gap_lock127", a_lock, 1);
    end
    chk("gap_cnt", a_cnt, 0);

    // narrow counter: saturation, then clear colliding with an error
    do_reset();
    gi = 0;
    clean_bits(64);
    chk("b_lock", b_lock, 1);
    chk("b_cnt0", b_cnt, 0);
    for (int i = 1; i <= 16; i++) begin
      err_bit(1'b0);
      chk("sat_err", b_err, 1);
      chk("sat_cnt", b_cnt, (i < 15) ? i : 15);
    end
    chk("sat_lock", b_lock, 1);
    err_bit(1'b1);
    chk("clr_cnt", b_cnt, 0);
    chk("clr_err", b_err, 1);
    err_bit(1'b0);
    chk("post_clr_cnt", b_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
